// File: rtl/memory_s_dp_param_bytes.sv
// Simple-dual-port byte-enabled SRAM model: one write and one read port on a shared clock,
// write-first same-address forwarding, 1- or 2-stage read pipeline, optional post-reset clear.
module memory_s_dp_param_bytes #(
  parameter int ADDR_WIDTH     = 11,
  parameter int BYTES          = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  sram_clock,
  input  logic                  sram_reset,
  output logic                  sram_ready,
  input  logic [BYTES-1:0]      sram_write_enable,
  input  logic [ADDR_WIDTH-1:0] sram_write_address,
  input  logic [8*BYTES-1:0]    sram_write_data,
  input  logic                  sram_read_enable,
  input  logic [ADDR_WIDTH-1:0] sram_read_address,
  output logic [8*BYTES-1:0]    sram_read_data,
  output logic                  sram_read_valid
);

  localparam int W     = 8 * BYTES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic [W-1:0]          mem_q [DEPTH];
  logic [BYTES-1:0]      wr_lane;
  logic                  rd_accept;
  logic [W-1:0]          rd_word;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [W-1:0]            dat_q [READ_LATENCY];
  logic [W-1:0]            dat_d [READ_LATENCY];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign sram_ready = (state_q == ST_READY) && !sram_reset;
  assign wr_lane    = sram_ready ? sram_write_enable : '0;
  assign rd_accept  = sram_ready && sram_read_enable;

  // Array has no reset; only the clear sequencer or accepted writes touch it.
  always_ff @(posedge sram_clock) begin
    if (!sram_reset && (state_q == ST_CLEAR)) begin
      mem_q[clr_cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wr_lane[i]) begin
          mem_q[sram_write_address][8*i +: 8] <= sram_write_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first per lane when both ports hit the same word in one cycle.
  always_comb begin
    rd_word = mem_q[sram_read_address];
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (wr_lane[i] && (sram_write_address == sram_read_address)) begin
        rd_word[8*i +: 8] = sram_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    vld_d[0] = rd_accept;
    dat_d[0] = rd_accept ? rd_word : '0;
    for (int unsigned s = 1; s < READ_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = vld_q[s-1] ? dat_q[s-1] : '0;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign sram_read_valid = vld_q[READ_LATENCY-1];
  assign sram_read_data  = dat_q[READ_LATENCY-1];

endmodule
